// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared coherence types for the snoop bus: transaction kinds, the bus message
// layout and the arbiter state encoding. CPU IDs are sized from SYS_NUM_CPUS,
// so a system with more CPUs must raise SYS_NUM_CPUS here as well.
package snoop_bus_arbiter_pkg;

    localparam int SYS_NUM_CPUS = 2;
    localparam int CPU_ID_WIDTH = $clog2(SYS_NUM_CPUS) + 1;
    localparam int ADDR_WIDTH   = 4;

    typedef enum logic [1:0] {
        Bus_Idle = 2'd0,
        Bus_Rd   = 2'd1,
        Bus_RdX  = 2'd2,
        Bus_Upgr = 2'd3
    } bus_tx_t;

    typedef struct packed {
        logic                    valid;
        logic [CPU_ID_WIDTH-1:0] source;
        logic [ADDR_WIDTH-1:0]   addr;
        bus_tx_t                 bus_tx;
    } bus_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BCAST = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    // A request only competes for the bus when it carries a real transaction.
    function automatic logic is_eligible(input bus_msg_t msg);
        return msg.valid && (msg.bus_tx != Bus_Idle);
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping modulo N. Shared with the crossbar.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    // Walk the candidates starting at ptr and keep only the first hit.
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any                = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: picks one coherence request per transaction round-robin,
// broadcasts it, gathers acks/shared from every other CPU and reports
// completion (or a timeout error) back to the requester.
module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int NUM_CPUS    = SYS_NUM_CPUS,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  bus_msg_t                req_msg [NUM_CPUS],
    output logic [NUM_CPUS-1:0]     req_ready,
    output bus_msg_t                bus_out,
    input  logic [NUM_CPUS-1:0]     snoop_ack,
    input  logic [NUM_CPUS-1:0]     snoop_shared,
    output logic                    done,
    output logic [CPU_ID_WIDTH-1:0] done_dest,
    output logic                    done_shared,
    output logic                    done_err
);

    localparam int PTR_W   = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

    arb_state_t          state, next_state;
    logic [PTR_W-1:0]    rr_ptr;
    bus_msg_t            msg_q;
    logic [NUM_CPUS-1:0] ack_mask;
    logic [NUM_CPUS-1:0] shared_acc;
    logic [TIMER_W-1:0]  timer;
    logic                err_q;

    logic [NUM_CPUS-1:0] eligible;
    logic [NUM_CPUS-1:0] grant_onehot;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_any;
    logic [PTR_W-1:0]    ptr_after;
    bus_msg_t            granted_msg;
    logic [NUM_CPUS-1:0] src_onehot;
    logic [NUM_CPUS-1:0] ack_next;
    logic [NUM_CPUS-1:0] shared_next;
    logic                all_acked;
    logic                timer_expired;

    rr_picker #(
        .N     (NUM_CPUS),
        .IDX_W (PTR_W)
    ) u_picker (
        .req          (eligible),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    // Request qualification, winner capture and ack bookkeeping for this cycle.
    always_comb begin
        eligible    = '0;
        src_onehot  = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            eligible[i]   = is_eligible(req_msg[i]);
            src_onehot[i] = (msg_q.source == CPU_ID_WIDTH'(i));
        end
        granted_msg        = req_msg[grant_idx];
        granted_msg.source = CPU_ID_WIDTH'(grant_idx);
        ptr_after     = (grant_idx == PTR_W'(NUM_CPUS - 1)) ? '0 : grant_idx + 1'b1;
        ack_next      = ack_mask | (snoop_ack & ~src_onehot);
        shared_next   = shared_acc | (snoop_ack & snoop_shared & ~src_onehot);
        all_acked     = &(ack_next | src_onehot);
        timer_expired = (timer == TIMER_W'(ACK_TIMEOUT - 1));
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and decoded outputs.
    always_comb begin
        next_state  = state;
        req_ready   = '0;
        bus_out     = '0;
        done        = 1'b0;
        done_dest   = '0;
        done_shared = 1'b0;
        done_err    = 1'b0;
        case (state)
            ARB_IDLE: begin
                req_ready = grant_onehot;
                if (grant_any) begin
                    next_state = ARB_BCAST;
                end
            end
            ARB_BCAST: begin
                bus_out       = msg_q;
                bus_out.valid = 1'b1;
                if (all_acked || timer_expired) begin
                    next_state = ARB_RESP;
                end
            end
            ARB_RESP: begin
                done        = 1'b1;
                done_dest   = msg_q.source;
                done_shared = |shared_acc;
                done_err    = err_q;
                next_state  = ARB_IDLE;
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // Transaction datapath: latch the winner, accumulate acks, run the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            msg_q      <= '0;
            ack_mask   <= '0;
            shared_acc <= '0;
            timer      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_any) begin
                        msg_q      <= granted_msg;
                        rr_ptr     <= ptr_after;
                        ack_mask   <= '0;
                        shared_acc <= '0;
                        timer      <= '0;
                        err_q      <= 1'b0;
                    end
                end
                ARB_BCAST: begin
                    ack_mask   <= ack_next;
                    shared_acc <= shared_next;
                    if (all_acked) begin
                        err_q <= 1'b0;
                    end else if (timer_expired) begin
                        err_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter with NUM_CPUS=2, ACK_TIMEOUT=15.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
module tb_snoop_bus_arbiter;
    import snoop_bus_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int TO = 15;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    bus_msg_t                req_msg [N];
    logic [N-1:0]            req_ready;
    bus_msg_t                bus_out;
    logic [N-1:0]            snoop_ack;
    logic [N-1:0]            snoop_shared;
    logic                    done;
    logic [CPU_ID_WIDTH-1:0] done_dest;
    logic                    done_shared;
    logic                    done_err;

    int total = 0;
    int bad   = 0;

    snoop_bus_arbiter #(
        .NUM_CPUS    (N),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_msg      (req_msg),
        .req_ready    (req_ready),
        .bus_out      (bus_out),
        .snoop_ack    (snoop_ack),
        .snoop_shared (snoop_shared),
        .done         (done),
        .done_dest    (done_dest),
        .done_shared  (done_shared),
        .done_err     (done_err)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    function automatic bus_msg_t mkMsg(input logic v, input logic [CPU_ID_WIDTH-1:0] src,
                                       input logic [3:0] a, input bus_tx_t t);
        bus_msg_t m;
        m.valid  = v;
        m.source = src;
        m.addr   = a;
        m.bus_tx = t;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input bus_tx_t t0, input logic [3:0] a0,
                                 input logic v1, input bus_tx_t t1, input logic [3:0] a1,
                                 input logic [1:0] ack, input logic [1:0] shr);
        req_msg[0]   = mkMsg(v0, '0, a0, t0);
        req_msg[1]   = mkMsg(v1, '0, a1, t1);
        snoop_ack    = ack;
        snoop_shared = shr;
        #1;
    endtask

    task automatic applyIdle;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b0, Bus_Idle, 4'h0, 2'b00, 2'b00);
    endtask

    task automatic doReset;
        tick;
        rst = 1'b1;
        applyIdle();
        tick;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyIdle();
        tick;
        tick;
        rst = 1'b0;
        applyIdle();
        $display("[TB] reset state");
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_bus_out", 32'(bus_out), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_done_dest", 32'(done_dest), 32'h0);
        checkOutput("rst_done_shared", 32'(done_shared), 32'h0);
        checkOutput("rst_done_err", 32'(done_err), 32'h0);

        $display("[TB] single request from CPU0");
        tick;
        applyStimulus(1'b1, Bus_Rd, 4'hA, 1'b0, Bus_Idle, 4'h0, 2'b00, 2'b00);
        checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
        tick;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b0, Bus_Idle, 4'h0, 2'b10, 2'b00);
        checkOutput("t1_bus_out", 32'(bus_out), 32'(mkMsg(1'b1, 2'd0, 4'hA, Bus_Rd)));
        checkOutput("t1_no_done_bcast", 32'(done), 32'h0);
        tick;
        applyIdle();
        checkOutput("t1_done", 32'(done), 32'h1);
        checkOutput("t1_dest", 32'(done_dest), 32'h0);
        checkOutput("t1_shared", 32'(done_shared), 32'h0);
        checkOutput("t1_err", 32'(done_err), 32'h0);
        checkOutput("t1_bus_idle", 32'(bus_out.valid), 32'h0);

        $display("[TB] alternating grants");
        doReset();
        applyStimulus(1'b1, Bus_Rd, 4'h1, 1'b1, Bus_RdX, 4'h2, 2'b11, 2'b00);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t2_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick;
            checkOutput("t2_bus_out", 32'(bus_out),
                        (k % 2 == 0) ? 32'(mkMsg(1'b1, 2'd0, 4'h1, Bus_Rd))
                                     : 32'(mkMsg(1'b1, 2'd1, 4'h2, Bus_RdX)));
            checkOutput("t2_no_grant_bcast", 32'(req_ready), 32'h0);
            tick;
            checkOutput("t2_done", 32'(done), 32'h1);
            checkOutput("t2_dest", 32'(done_dest), 32'(k % 2));
            checkOutput("t2_no_grant_resp", 32'(req_ready), 32'h0);
            tick;
        end
        applyIdle();

        $display("[TB] source acks ignored, shared collected");
        tick;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b1, Bus_RdX, 4'h5, 2'b00, 2'b00);
        checkOutput("t3_grant", 32'(req_ready), 32'h2);
        tick;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b0, Bus_Idle, 4'h0, 2'b10, 2'b10);
        checkOutput("t3_bus_out", 32'(bus_out), 32'(mkMsg(1'b1, 2'd1, 4'h5, Bus_RdX)));
        tick;
        checkOutput("t3_src_ack_no_done", 32'(done), 32'h0);
        checkOutput("t3_still_bcast", 32'(bus_out.valid), 32'h1);
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b0, Bus_Idle, 4'h0, 2'b11, 2'b01);
        tick;
        applyIdle();
        checkOutput("t3_done", 32'(done), 32'h1);
        checkOutput("t3_dest", 32'(done_dest), 32'h1);
        checkOutput("t3_shared", 32'(done_shared), 32'h1);
        checkOutput("t3_err", 32'(done_err), 32'h0);
        tick;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b1, Bus_RdX, 4'h6, 2'b00, 2'b00);
        checkOutput("t3b_grant", 32'(req_ready), 32'h2);
        tick;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b0, Bus_Idle, 4'h0, 2'b11, 2'b10);
        tick;
        applyIdle();
        checkOutput("t3b_done", 32'(done), 32'h1);
        checkOutput("t3b_src_shared_ignored", 32'(done_shared), 32'h0);

        $display("[TB] ack timeout");
        tick;
        applyStimulus(1'b1, Bus_Upgr, 4'h7, 1'b0, Bus_Idle, 4'h0, 2'b00, 2'b00);
        checkOutput("t4_grant", 32'(req_ready), 32'h1);
        for (int c = 1; c <= TO; c++) begin
            tick;
            applyIdle();
            checkOutput("t4_bcast_valid", 32'(bus_out.valid), 32'h1);
            checkOutput("t4_no_done", 32'(done), 32'h0);
        end
        tick;
        checkOutput("t4_done", 32'(done), 32'h1);
        checkOutput("t4_err", 32'(done_err), 32'h1);
        checkOutput("t4_dest", 32'(done_dest), 32'h0);
        checkOutput("t4_shared", 32'(done_shared), 32'h0);
        checkOutput("t4_resp_bus_idle", 32'(bus_out.valid), 32'h0);
        tick;
        checkOutput("t4_after_done", 32'(done), 32'h0);
        checkOutput("t4_after_err", 32'(done_err), 32'h0);
        checkOutput("t4_after_bus", 32'(bus_out.valid), 32'h0);

        $display("[TB] reset during broadcast");
        tick;
        applyStimulus(1'b1, Bus_Rd, 4'h3, 1'b0, Bus_Idle, 4'h0, 2'b00, 2'b00);
        checkOutput("t5_grant0", 32'(req_ready), 32'h1);
        tick;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b1, Bus_Rd, 4'h9, 2'b00, 2'b00);
        checkOutput("t5_bcast1", 32'(bus_out.valid), 32'h1);
        tick;
        rst = 1'b1;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b1, Bus_Rd, 4'h9, 2'b00, 2'b00);
        checkOutput("t5_bcast2", 32'(bus_out.valid), 32'h1);
        tick;
        rst = 1'b0;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b1, Bus_Rd, 4'h9, 2'b00, 2'b00);
        checkOutput("t5_bus_out", 32'(bus_out), 32'h0);
        checkOutput("t5_done", 32'(done), 32'h0);
        checkOutput("t5_done_err", 32'(done_err), 32'h0);
        checkOutput("t5_done_dest", 32'(done_dest), 32'h0);
        checkOutput("t5_done_shared", 32'(done_shared), 32'h0);
        checkOutput("t5_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        checkOutput("t5_grant1", 32'(req_ready), 32'h2);
        tick;
        applyStimulus(1'b0, Bus_Idle, 4'h0, 1'b0, Bus_Idle, 4'h0, 2'b01, 2'b00);
        checkOutput("t5_bus_out_cpu1", 32'(bus_out), 32'(mkMsg(1'b1, 2'd1, 4'h9, Bus_Rd)));
        checkOutput("t5_no_done_bcast", 32'(done), 32'h0);
        tick;
        applyIdle();
        checkOutput("t5_done_after", 32'(done), 32'h1);
        checkOutput("t5_dest_after", 32'(done_dest), 32'h1);

        $display("[TB] Bus_Idle requests never granted");
        tick;
        applyStimulus(1'b1, Bus_Idle, 4'hF, 1'b1, Bus_Idle, 4'hE, 2'b11, 2'b00);
        for (int c = 0; c < 4; c++) begin
            checkOutput("t6_req_ready", 32'(req_ready), 32'h0);
            checkOutput("t6_bus_valid", 32'(bus_out.valid), 32'h0);
            checkOutput("t6_done", 32'(done), 32'h0);
            tick;
        end
        applyIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Arbitrates coherence requests from the per-CPU cache controllers onto the single shared snoop bus and sequences each transaction to completion. Each cycle it selects at most one `bus_msg_t` request by round-robin and broadcasts it to all caches. It collects snoop acknowledgements and a "shared" indication from every non-requesting CPU, then signals completion so the requester can settle in E or S. It sits directly upstream of the caches' snoop ports and downstream of their miss handlers.

## Interface
- `NUM_CPUS`, 2: number of requesters/snoopers; must be ≥1.
- `ACK_TIMEOUT`, 15: maximum BCAST cycles spent waiting for acks before a forced error completion; must be ≥1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_msg`  in  `bus_msg_t [NUM_CPUS]`  per-CPU request; `req_msg[i].valid` qualifies it.
- `req_ready`  out  `[NUM_CPUS]`  one-cycle accept pulse to the granted CPU.
- `bus_out`  out  `bus_msg_t`  broadcast transaction; `valid` is high only in BCAST.
- `snoop_ack`  in  `[NUM_CPUS]`  per-CPU "snoop done" for the current broadcast.
- `snoop_shared`  in  `[NUM_CPUS]`  per-CPU "I hold this line"; sampled only when the matching ack is high.
- `done`  out  1  one-cycle completion pulse.
- `done_dest`  out  `CPU_ID_WIDTH`  requester ID for the completing transaction.
- `done_shared`  out  1  any snooper reported shared: requester installs S, else E.
- `done_err`  out  1  completion forced by timeout.

## Operation
- FSM `ARB_IDLE`:
  - Eligible requests have `valid=1` and `bus_tx != Bus_Idle`.
  - If any request is eligible, grant the first eligible index at or after `rr_ptr`, searching modulo `NUM_CPUS`.
  - Pulse `req_ready[w]` combinationally in this cycle.
  - Latch the message and overwrite `source` with `w`.
  - Set `rr_ptr <= (w+1) % NUM_CPUS`, clear `ack_mask`, `shared_acc` and `timer`, then go to `ARB_BCAST`.
  - Non-eligible `valid` requests are never granted.
- `ARB_BCAST`:
  - Drive `bus_out` = latched message with `valid=1`.
  - Update `ack_mask |= snoop_ack & ~src_onehot` and `shared_acc |= snoop_ack & snoop_shared & ~src_onehot`.
  - The current-cycle acks count toward completion in the same cycle.
  - When the combined mask covers all non-source CPUs, go to `ARB_RESP` with `err=0`.
  - Else if `timer == ACK_TIMEOUT-1`, go to `ARB_RESP` with `err=1`.
  - Otherwise increment `timer`.
- `ARB_RESP`:
  - `done=1`, `done_dest` = latched source, `done_shared = |shared_acc`, `done_err` = latched err.
  - Go to `ARB_IDLE`. No grant is made in this state.
- Acks from the source CPU, and any acks received in IDLE or RESP, are ignored.
- A repeated ack from the same CPU is idempotent.
- `NUM_CPUS=1`: there are no snoopers, so the mask is trivially complete and the FSM spends exactly one cycle in BCAST.
- `timer` width is `$clog2(ACK_TIMEOUT+1)`. It is compared, never wrapped.

## Timing
- Reset values: state `ARB_IDLE`, `rr_ptr=0`, masks and timer 0. All outputs are 0, including every `bus_out` field.
- Minimum transaction: request/grant in cycle 0, `bus_out.valid` in cycle 1 with acks arriving in cycle 1, `done` in cycle 2, next grant in cycle 3.
- Throughput: at most one transaction per 3 cycles.
- `req_ready` depends combinationally on `req_msg` in IDLE. All other outputs are registered-state decodes.
- Requesters must hold `req_msg` stable until `req_ready`. A request may be withdrawn before grant with no side effects.
- `rst` in any state aborts the transaction in the same edge. No `done` is produced, and the requester's controller must re-issue.
- Timeout path: grant at cycle 0, BCAST in cycles 1..`ACK_TIMEOUT`, `done`+`done_err` at cycle `ACK_TIMEOUT+1`.

## Structure
- Add to the shared types package:
  - `CPU_ID_WIDTH = $clog2(NUM_CPUS)+1`, matching the `source` and `destination` fields.
  - `typedef enum {ARB_IDLE, ARB_BCAST, ARB_RESP} arb_state_t`.
- `ACK_TIMEOUT` stays a module parameter.
- One sub-module, `rr_picker`:
  - Combinational.
  - Inputs: `req [NUM_CPUS]`, `ptr`.
  - Outputs: `grant_onehot`, `grant_idx`, `any`.
  - Reusable by the crossbar.

## Test plan
- Single request, CPU0 `Bus_Rd` addr 4'hA with `NUM_CPUS=2`, CPU1 acks with shared=0 in cycle 1 → `req_ready=2'b01` in cycle 0, `bus_out={1,0,4'hA,Bus_Rd}` in cycle 1, `done` with `dest=0`, `shared=0`, `err=0` in cycle 2.
- Both CPUs request continuously, immediate acks → grants alternate 0,1,0,1 at cycles 0,3,6,9.
- CPU1 request, CPU0 acks with shared=1 and CPU1 also (spuriously) acks → `done_shared=1`. A source-only ack (CPU0 silent) does not complete the transaction.
- No acks → BCAST lasts exactly 15 cycles, then `done=1`, `done_err=1` at cycle 16, then IDLE.
- `rst` asserted in cycle 2 of BCAST → all outputs 0 next cycle, no `done`, `rr_ptr=0`, and a pending CPU1 request is granted first after reset.
- Request with `valid=1`, `bus_tx=Bus_Idle` → never granted, `req_ready` stays 0, `bus_out.valid` stays 0.
